// File: rtl/alu_ctrl_seq_decoder.sv
// Registered ALU control decoder with a start/done sequencer for an external mult/div unit.
// Optional feature: define ILLEGAL_TRAP_EN to flag unsupported R-type funct codes on `illegal`.
module alu_ctrl_seq_decoder #(
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned MDU_MAX = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         funct,
  input  logic               mdu_done,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               out_valid,
  output logic               stall,
  output logic               mdu_start,
  output logic [1:0]         mdu_op,
  output logic               illegal,
  output logic               mdu_err
);

  localparam int unsigned CNT_W = $clog2(MDU_MAX + 1);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_NOR  = 4'b0100;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_SLL  = 4'b1001;
  localparam logic [3:0] C_SRL  = 4'b1010;
  localparam logic [3:0] C_SRA  = 4'b1011;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             err_next, start_next;
  logic [3:0]       code;
  logic             dec_alu, dec_mdu;
  logic             accept;

  assign stall  = (state == BUSY);
  assign accept = in_valid & ~stall;

  always_comb begin
    code    = '0;
    dec_alu = 1'b0;
    dec_mdu = 1'b0;
    case (alu_op[1:0])
      2'b00: begin code = C_ADD; dec_alu = 1'b1; end
      2'b01: begin code = C_SUB; dec_alu = 1'b1; end
      2'b11: begin code = C_SLT; dec_alu = 1'b1; end
      default: begin
        dec_alu = 1'b1;
        case (funct)
          6'b100000, 6'b100001: code = C_ADD;
          6'b100010, 6'b100011: code = C_SUB;
          6'b100100: code = C_AND;
          6'b100101: code = C_OR;
          6'b100110: code = C_XOR;
          6'b100111: code = C_NOR;
          6'b101010: code = C_SLT;
          6'b101011: code = C_SLTU;
          6'b000000: code = C_SLL;
          6'b000010: code = C_SRL;
          6'b000011: code = C_SRA;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            dec_alu = 1'b0;
            dec_mdu = 1'b1;
          end
          default: dec_alu = 1'b0;
        endcase
      end
    endcase
  end

  // mdu_done is masked while mdu_start is high: that is the launch cycle.
  always_comb begin
    state_next = state;
    count_next = count;
    err_next   = mdu_err;
    start_next = 1'b0;
    case (state)
      IDLE: begin
        if (accept && dec_mdu) begin
          start_next = 1'b1;
          state_next = BUSY;
          count_next = '0;
        end
      end
      BUSY: begin
        count_next = count + 1'b1;
        if (mdu_done && !mdu_start) begin
          state_next = IDLE;
        end else if (count_next == CNT_W'(MDU_MAX)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      mdu_err   <= 1'b0;
      mdu_start <= 1'b0;
      mdu_op    <= '0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      mdu_err   <= err_next;
      mdu_start <= start_next;
      if (start_next) mdu_op <= funct[1:0];
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic dec_bad;
  assign dec_bad = (alu_op[1:0] == 2'b10) & ~dec_alu & ~dec_mdu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_ctrl  <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= accept & dec_alu;
      illegal   <= accept & dec_bad;
      if (accept && dec_alu)      alu_ctrl <= CTRL_W'(code);
      else if (accept && dec_bad) alu_ctrl <= '0;
    end
  end
`else
  assign illegal = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_ctrl  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept & dec_alu;
      if (accept && dec_alu) alu_ctrl <= CTRL_W'(code);
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_seq_decoder.sv
// Self-checking bench for alu_ctrl_seq_decoder: directed scenarios plus random traffic
// compared against a table-driven transaction-level reference model.
module tb_alu_ctrl_seq_decoder;

  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned MDU_MAX = 32;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic [ALUOP_W-1:0] alu_op;
  logic [5:0]        funct;
  logic              mdu_done;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              out_valid, stall, mdu_start, illegal, mdu_err;
  logic [1:0]        mdu_op;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_decoder #(.CTRL_W(CTRL_W), .ALUOP_W(ALUOP_W), .MDU_MAX(MDU_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .alu_op(alu_op), .funct(funct),
    .mdu_done(mdu_done), .alu_ctrl(alu_ctrl), .out_valid(out_valid), .stall(stall),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .illegal(illegal), .mdu_err(mdu_err)
  );

  // Reference model: funct lookup table (0 = ALU op, 1 = MDU op, 2 = unsupported)
  int         kind_tbl [64];
  int         code_tbl [64];
  bit         m_busy;
  int         m_cycles;
  bit         m_err, m_start, m_valid, m_illegal;
  int         m_ctrl, m_op;
  logic [5:0] legal_f [11];

  task automatic model_reset();
    m_busy = 0; m_cycles = 0; m_err = 0; m_start = 0;
    m_valid = 0; m_illegal = 0; m_ctrl = 0; m_op = 0;
  endtask

  // Advances the model by one rising edge using the inputs present at that edge.
  task automatic model_tick();
    int  kind, code;
    bit  acc;
    acc = in_valid && !m_busy;
    if (alu_op == 2'd0)      begin kind = 0; code = 2; end
    else if (alu_op == 2'd1) begin kind = 0; code = 6; end
    else if (alu_op == 2'd3) begin kind = 0; code = 7; end
    else begin kind = kind_tbl[funct]; code = code_tbl[funct]; end
    m_valid   = acc && kind == 0;
    m_illegal = TRAP && acc && kind == 2;
    if (m_valid) m_ctrl = code;
    if (m_illegal) m_ctrl = 0;
    if (m_busy) begin
      m_cycles++;
      if (mdu_done && !m_start) m_busy = 0;
      else if (m_cycles == MDU_MAX) begin m_err = 1; m_busy = 0; end
      m_start = 0;
    end else begin
      m_start = 0;
      if (acc && kind == 1) begin
        m_busy = 1; m_cycles = 0; m_start = 1; m_op = funct[1:0];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("stall", 32'(stall), 32'(m_busy));
    chk("mdu_start", 32'(mdu_start), 32'(m_start));
    chk("mdu_op", 32'(mdu_op), 32'(m_op));
    chk("illegal", 32'(illegal), 32'(m_illegal));
    chk("mdu_err", 32'(mdu_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!reset_n) model_reset();
    else model_tick();
    check_all();
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] f, input bit d);
    in_valid = v; alu_op = op; funct = f; mdu_done = d;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin kind_tbl[i] = 2; code_tbl[i] = 0; end
    kind_tbl[6'o40] = 0; code_tbl[6'o40] = 2;
    kind_tbl[6'o41] = 0; code_tbl[6'o41] = 2;
    kind_tbl[6'o42] = 0; code_tbl[6'o42] = 6;
    kind_tbl[6'o43] = 0; code_tbl[6'o43] = 6;
    kind_tbl[6'o44] = 0; code_tbl[6'o44] = 0;
    kind_tbl[6'o45] = 0; code_tbl[6'o45] = 1;
    kind_tbl[6'o46] = 0; code_tbl[6'o46] = 3;
    kind_tbl[6'o47] = 0; code_tbl[6'o47] = 4;
    kind_tbl[6'o52] = 0; code_tbl[6'o52] = 7;
    kind_tbl[6'o53] = 0; code_tbl[6'o53] = 8;
    kind_tbl[6'o00] = 0; code_tbl[6'o00] = 9;
    kind_tbl[6'o02] = 0; code_tbl[6'o02] = 10;
    kind_tbl[6'o03] = 0; code_tbl[6'o03] = 11;
    for (int i = 24; i < 28; i++) kind_tbl[i] = 1;
    legal_f = '{6'o40, 6'o42, 6'o44, 6'o45, 6'o46, 6'o47, 6'o52, 6'o53, 6'o00, 6'o02, 6'o03};
    model_reset();

    // Reset held with a valid request present: everything stays zero.
    reset_n = 1'b0;
    drive(1, 2'b10, 6'b100000, 0);
    repeat (3) step();
    #2 reset_n = 1'b1;

    // First accept after release, then nor and sub.
    drive(1, 2'b10, 6'b100111, 0);
    step();
    chk("nor_code", 32'(alu_ctrl), 32'h4);
    drive(1, 2'b01, 6'b100111, 0);
    step();
    chk("sub_code", 32'(alu_ctrl), 32'h6);
    drive(0, 2'b00, 6'b000000, 0);
    step();
    step();

    // div launch, a blocked add while busy, done in the fifth busy cycle.
    drive(1, 2'b10, 6'b011010, 0);
    step();
    chk("div_start", 32'(mdu_start), 32'h1);
    chk("div_op", 32'(mdu_op), 32'h2);
    drive(1, 2'b00, 6'b000000, 0);
    repeat (4) step();
    drive(0, 2'b00, 6'b000000, 1);
    step();
    chk("div_released", 32'(stall), 32'h0);
    drive(0, 2'b00, 6'b000000, 0);
    step();

    // multu launch with no done: timeout after MDU_MAX busy cycles.
    drive(1, 2'b10, 6'b011001, 0);
    step();
    drive(0, 2'b00, 6'b000000, 0);
    repeat (MDU_MAX - 1) step();
    chk("pre_timeout_stall", 32'(stall), 32'h1);
    step();
    chk("timeout_err", 32'(mdu_err), 32'h1);
    chk("timeout_stall", 32'(stall), 32'h0);
    drive(1, 2'b00, 6'b000000, 0);
    step();
    chk("post_err_add", 32'(alu_ctrl), 32'h2);

    // Unsupported funct.
    drive(1, 2'b10, 6'b111111, 0);
    step();
    chk("bad_funct_illegal", 32'(illegal), 32'(TRAP));
    drive(0, 2'b00, 6'b000000, 0);
    step();

    // Random traffic; done is never raised in a launch cycle.
    for (int n = 0; n < 400; n++) begin
      logic [5:0] f;
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)      f = legal_f[$urandom_range(0, 10)];
      else if (r < 7) f = 6'b011000 | 6'($urandom_range(0, 3));
      else            f = 6'($urandom);
      drive($urandom_range(0, 3) != 0, 2'($urandom), f,
            !m_start && ($urandom_range(0, 5) == 0));
      step();
    end

    // Asynchronous reset in the middle of a busy period.
    drive(1, 2'b10, 6'b011000, 0);
    step();
    drive(0, 2'b00, 6'b000000, 0);
    repeat (3) step();
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_stall", 32'(stall), 32'h0);
    chk("async_err", 32'(mdu_err), 32'h0);
    chk("async_op", 32'(mdu_op), 32'h0);
    step();
    #2 reset_n = 1'b1;
    drive(1, 2'b11, 6'b000000, 0);
    step();
    chk("after_reset_slt", 32'(alu_ctrl), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
